// File: rtl/sonic_pkg.sv
// Shared types and constants for the multi-channel ultrasonic ranging engine.
package sonic_pkg;

    typedef enum logic [2:0] {
        IDLE,
        TRIG,
        WAIT_RISE,
        MEASURE,
        GUARD
    } state_t;

    // Round-trip sound travel time for one centimetre of range.
    localparam int US_PER_CM = 58;

    // Clock cycles per microsecond strobe; CLK_HZ is a whole number of MHz.
    function automatic int tick_div(input int clk_hz);
        return clk_hz / 1_000_000;
    endfunction

endpackage

// File: rtl/sonic_tick.sv
// Free-running microsecond strobe generator: one-cycle pulse every CLK_HZ/1e6 cycles.
module sonic_tick
    import sonic_pkg::*;
#(
    parameter int CLK_HZ = 100_000_000
) (
    input  logic clk,
    input  logic rst,
    output logic us_tick
);
    localparam int DIV = tick_div(CLK_HZ);
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    // At 1 MHz the divider collapses to a constant strobe.
    assign us_tick = (cnt == LAST);

    // Prescaler counts 0..DIV-1 and restarts on each strobe.
    always_ff @(posedge clk) begin
        if (rst || us_tick) cnt <= '0;
        else                cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/sonic_scanner.sv
// Round-robin multi-channel ultrasonic ranging engine.
// Optional feature: define SONIC_AVG_EN to store (old + new) >> 1 instead of the raw sample.
module sonic_scanner
    import sonic_pkg::*;
#(
    parameter int CH         = 4,
    parameter int CLK_HZ     = 100_000_000,
    parameter int DIST_W     = 9,
    parameter int TRIG_US    = 10,
    parameter int TIMEOUT_US = 25_000,
    parameter int GUARD_US   = 10_000,
    localparam int CHW       = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic [CH-1:0]        echo,
    output logic [CH-1:0]        trig,
    output logic [CH*DIST_W-1:0] distance,
    output logic [CH-1:0]        timeout,
    output logic                 valid,
    output logic [CHW-1:0]       valid_ch
);
    localparam int MAXU = (TIMEOUT_US > GUARD_US) ?
                          ((TIMEOUT_US > TRIG_US) ? TIMEOUT_US : TRIG_US) :
                          ((GUARD_US > TRIG_US) ? GUARD_US : TRIG_US);
    localparam int UW = $clog2(MAXU + 1);
    localparam int SW = $clog2(US_PER_CM);

    state_t            state, nxt;
    logic              us_tick;
    logic [CH-1:0]     sync1, sync2, sync3;
    logic [CHW-1:0]    ch;
    logic [UW-1:0]     us_cnt;
    logic [SW-1:0]     sub;
    logic [DIST_W-1:0] cm, sample;
    logic              rise, fall, to_hit;
    logic              us_clr, start_cm, store, expire, adv;

    sonic_tick #(.CLK_HZ(CLK_HZ)) u_tick (
        .clk     (clk),
        .rst     (rst),
        .us_tick (us_tick)
    );

    // Two-flop synchroniser plus one history flop for edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
            sync3 <= '0;
        end else begin
            sync1 <= echo;
            sync2 <= sync1;
            sync3 <= sync2;
        end
    end

    // Only the selected channel's edges matter; a level already high gives no edge.
    assign rise   = sync2[ch] & ~sync3[ch];
    assign fall   = ~sync2[ch] & sync3[ch];
    assign to_hit = (us_cnt == UW'(TIMEOUT_US - 1));

`ifdef SONIC_AVG_EN
    logic [CH-1:0]     seen;
    logic [DIST_W-1:0] old;
    logic [DIST_W:0]   sum;
    assign old    = distance[ch*DIST_W +: DIST_W];
    assign sum    = {1'b0, old} + {1'b0, cm};
    // Load directly when there is no real history to average against.
    assign sample = (!seen[ch] || timeout[ch]) ? cm : sum[DIST_W:1];

    // Tracks which channels have produced a result since reset.
    always_ff @(posedge clk) begin
        if (rst)                  seen     <= '0;
        else if (store || expire) seen[ch] <= 1'b1;
    end
`else
    assign sample = cm;
`endif

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= nxt;
    end

    // Next-state and control strobes; the falling edge beats a simultaneous timeout.
    always_comb begin
        nxt      = state;
        us_clr   = 1'b0;
        start_cm = 1'b0;
        store    = 1'b0;
        expire   = 1'b0;
        adv      = 1'b0;
        case (state)
            IDLE: if (enable && us_tick) begin
                nxt    = TRIG;
                us_clr = 1'b1;
            end
            TRIG: if (us_tick && us_cnt == UW'(TRIG_US - 1)) begin
                nxt    = WAIT_RISE;
                us_clr = 1'b1;
            end
            WAIT_RISE: if (us_tick && to_hit) begin
                nxt    = GUARD;
                expire = 1'b1;
                us_clr = 1'b1;
            end else if (rise) begin
                nxt      = MEASURE;
                start_cm = 1'b1;
            end
            MEASURE: if (fall) begin
                nxt    = GUARD;
                store  = 1'b1;
                us_clr = 1'b1;
            end else if (us_tick && to_hit) begin
                nxt    = GUARD;
                expire = 1'b1;
                us_clr = 1'b1;
            end
            GUARD: if (us_tick && us_cnt == UW'(GUARD_US - 1)) begin
                nxt    = enable ? TRIG : IDLE;
                adv    = 1'b1;
                us_clr = 1'b1;
            end
            default: nxt = IDLE;
        endcase
    end

    // Microsecond counter; runs through WAIT_RISE and MEASURE so the timeout spans both.
    always_ff @(posedge clk) begin
        if (rst || us_clr)                  us_cnt <= '0;
        else if (us_tick && state != IDLE)  us_cnt <= us_cnt + 1'b1;
    end

    // Centimetre conversion; the rise cycle's tick counts as the first of the pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            sub <= '0;
            cm  <= '0;
        end else if (start_cm) begin
            sub <= us_tick ? SW'(1) : '0;
            cm  <= '0;
        end else if (state == MEASURE && us_tick) begin
            if (sub == SW'(US_PER_CM - 1)) begin
                sub <= '0;
                if (cm != {DIST_W{1'b1}}) cm <= cm + 1'b1;
            end else begin
                sub <= sub + 1'b1;
            end
        end
    end

    // Channel pointer moves only when a guard interval completes.
    always_ff @(posedge clk) begin
        if (rst)      ch <= '0;
        else if (adv) ch <= (ch == CHW'(CH - 1)) ? '0 : ch + 1'b1;
    end

    // Result registers and the update strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            distance <= '0;
            timeout  <= '0;
            valid    <= 1'b0;
            valid_ch <= '0;
        end else begin
            valid <= store | expire;
            if (store || expire) valid_ch <= ch;
            if (store) begin
                distance[ch*DIST_W +: DIST_W] <= sample;
                timeout[ch]                   <= 1'b0;
            end else if (expire) begin
                distance[ch*DIST_W +: DIST_W] <= '1;
                timeout[ch]                   <= 1'b1;
            end
        end
    end

    // Trigger is decoded from registered state, so reset drops it on the next edge.
    always_comb begin
        trig = '0;
        if (state == TRIG) trig[ch] = 1'b1;
    end
endmodule

// File: tb/tb_sonic_scanner.sv
// Self-checking bench for sonic_scanner at CLK_HZ = 1 MHz (one us_tick per cycle).
// The main DUT is checked every cycle against a schedule model of when triggers fire
// and when each result lands; a second DUT with DIST_W=6 covers saturation.
module tb_sonic_scanner;
    localparam int CH = 4, DW = 9, TO = 25000, GU = 100, TR = 10;
`ifdef SONIC_AVG_EN
    localparam bit AVG = 1'b1;
`else
    localparam bit AVG = 1'b0;
`endif

    logic clk = 1'b0, rst = 1'b1, enable = 1'b0;
    logic [CH-1:0] echo = '0, trig, timeout;
    logic [CH*DW-1:0] distance;
    logic valid;
    logic [1:0] valid_ch;

    logic rst_s = 1'b1, en_s = 1'b1;
    logic [0:0] echo_s = '0, trig_s, timeout_s, valid_ch_s;
    logic [5:0] distance_s;
    logic valid_s;

    always #5 clk = ~clk;

    sonic_scanner #(.CH(CH), .CLK_HZ(1_000_000), .DIST_W(DW), .TRIG_US(TR),
                    .TIMEOUT_US(TO), .GUARD_US(GU)) dut (
        .clk(clk), .rst(rst), .enable(enable), .echo(echo), .trig(trig),
        .distance(distance), .timeout(timeout), .valid(valid), .valid_ch(valid_ch));

    sonic_scanner #(.CH(1), .CLK_HZ(1_000_000), .DIST_W(6), .TRIG_US(TR),
                    .TIMEOUT_US(TO), .GUARD_US(GU)) dut_s (
        .clk(clk), .rst(rst_s), .enable(en_s), .echo(echo_s), .trig(trig_s),
        .distance(distance_s), .timeout(timeout_s), .valid(valid_s), .valid_ch(valid_ch_s));

    int n_chk = 0, n_fail = 0;
    bit chk_en = 1'b0, sat_done = 1'b0;
    int cur_ch = 0;

    // Expected outputs for the next negedge sample.
    logic [CH-1:0] exp_trig = '0;
    bit exp_valid = 1'b0;
    int exp_vch = 0;
    int exp_dist[CH];
    bit exp_to[CH];
    bit has[CH];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, req, $time);
        end
    endtask

    // Stored value for a completed pulse given the previous register contents.
    function automatic int upd(input int old, input int raw, input bit direct);
        if (AVG && !direct) return (old + raw) / 2;
        return raw;
    endfunction

    function automatic int to_cm(input int h, input int w);
        int v = h / 58;
        return (v > (1 << w) - 1) ? (1 << w) - 1 : v;
    endfunction

    // Compare every output against the model on every cycle.
    always @(negedge clk) if (chk_en) begin
        chk("trig", trig, exp_trig);
        chk("valid", valid, exp_valid);
        if (exp_valid) chk("valid_ch", valid_ch, exp_vch);
        for (int i = 0; i < CH; i++) begin
            chk("distance", distance[i*DW +: DW], exp_dist[i]);
            chk("timeout", timeout[i], exp_to[i]);
        end
    end

    // Advance one cycle; unselected echo lines toggle at random.
    task automatic step();
        @(negedge clk);
        #1;
        for (int j = 0; j < CH; j++)
            if (j != cur_ch && $urandom_range(15) == 0) echo[j] = ~echo[j];
    endtask

    // One full measurement starting with trig on the next sample.
    task automatic run(input int c, input int d, input int h, input bit to, input bit pre, input bit drop);
        cur_ch = c;
        echo[c] = pre;
        exp_trig = '0;
        exp_trig[c] = 1'b1;
        repeat (TR) step();
        exp_trig = '0;
        if (to) begin
            repeat (TO) step();
            exp_dist[c] = (1 << DW) - 1;
            exp_to[c] = 1'b1;
        end else begin
            if (pre) begin
                repeat (d - 4) step();
                echo[c] = 1'b0;
                repeat (5) step();
            end else begin
                repeat (d + 1) step();
            end
            echo[c] = 1'b1;
            if (drop) enable = 1'b0;
            repeat (h) step();
            echo[c] = 1'b0;
            repeat (2) step();
            exp_dist[c] = upd(exp_dist[c], to_cm(h, DW), !has[c] || exp_to[c]);
            exp_to[c] = 1'b0;
        end
        has[c] = 1'b1;
        exp_valid = 1'b1;
        exp_vch = c;
        step();
        exp_valid = 1'b0;
    endtask

    task automatic guard();
        repeat (GU - 1) step();
    endtask

    task automatic clear_model();
        exp_trig = '0;
        exp_valid = 1'b0;
        for (int i = 0; i < CH; i++) begin
            exp_dist[i] = 0;
            exp_to[i] = 1'b0;
            has[i] = 1'b0;
        end
    endtask

    // Saturating DUT: pulse widths straddling the 63 cm ceiling.
    initial begin : sat
        int hs[4];
        int raw[4];
        int e;
        bit first;
        bit got;
        hs = '{4060, 3654, 3653, 600};
        raw = '{63, 63, 62, 10};
        e = 0;
        first = 1'b1;
        repeat (3) @(negedge clk);
        rst_s = 1'b0;
        for (int k = 0; k < 4; k++) begin
            for (int t = 0; t < 500 && trig_s !== 1'b1; t++) @(negedge clk);
            chk("sat trig rise", trig_s, 1);
            for (int t = 0; t < 50 && trig_s !== 1'b0; t++) @(negedge clk);
            repeat (20) @(negedge clk);
            echo_s = 1'b1;
            repeat (hs[k]) @(negedge clk);
            echo_s = 1'b0;
            got = 1'b0;
            for (int t = 0; t < 10 && !got; t++) begin
                @(negedge clk);
                if (valid_s === 1'b1) got = 1'b1;
            end
            chk("sat valid", got, 1);
            e = upd(e, raw[k], first);
            first = 1'b0;
            chk("sat distance", distance_s, e);
            chk("sat timeout", timeout_s, 0);
        end
        sat_done = 1'b1;
    end

    initial begin : main
        clear_model();
        repeat (3) @(negedge clk);
        #1;
        chk_en = 1'b1;
        chk("reset trig", trig, 0);
        chk("reset distance", |distance, 0);
        chk("reset timeout", timeout, 0);
        chk("reset valid", valid, 0);
        chk("reset valid_ch", valid_ch, 0);
        step();
        rst = 1'b0;
        enable = 1'b1;

        run(0, 100, 580, 0, 0, 0);
        chk("ch0 580us", distance[0 +: DW], 10);
        chk("ch0 timeout", timeout[0], 0);
        guard();
        run(1, $urandom_range(5, 400), $urandom_range(58, 3000), 0, 0, 0);
        guard();
        run(2, 0, 0, 1, 0, 0);
        chk("ch2 timeout dist", distance[2*DW +: DW], 511);
        chk("ch2 timeout flag", timeout[2], 1);
        guard();
        run(3, 50, $urandom_range(100, 2000), 0, 1, 0);
        guard();
        run(0, $urandom_range(5, 300), 1160, 0, 0, 0);
        chk("ch0 second sample", distance[0 +: DW], AVG ? 15 : 20);
        guard();
        run(1, $urandom_range(5, 300), $urandom_range(58, 2000), 0, 0, 1);
        repeat (300) step();
        enable = 1'b1;
        run(2, $urandom_range(5, 300), $urandom_range(58, 2000), 0, 0, 0);
        chk("ch2 flag cleared", timeout[2], 0);
        guard();
        run(3, 100, 24897, 0, 0, 0);
        chk("fall vs timeout", timeout[3], 0);
        guard();
        run(0, $urandom_range(5, 300), $urandom_range(58, 2000), 0, 0, 0);
        guard();

        // Reset in the middle of a trigger pulse on channel 1.
        cur_ch = 1;
        exp_trig = 4'b0010;
        repeat (5) step();
        rst = 1'b1;
        clear_model();
        repeat (3) step();
        chk("midrst distance", |distance, 0);
        chk("midrst valid_ch", valid_ch, 0);
        rst = 1'b0;
        run(0, $urandom_range(5, 300), $urandom_range(58, 2000), 0, 0, 0);
        guard();
        run(1, $urandom_range(5, 300), $urandom_range(58, 2000), 0, 0, 0);

        for (int t = 0; t < 20000 && !sat_done; t++) @(negedge clk);
        chk("sat finished", sat_done, 1);
        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/sonic_scanner.md
# sonic_scanner

Parametrised multi-channel ultrasonic ranging engine; successor to the single-sensor `Sonic` path. It drives CH trig/echo sensor pairs round-robin from one system clock, converts each echo pulse width to centimetres, and flags timeouts. Per-channel distance registers feed the LED/display and control logic. The internal microsecond prescaler removes the external 8 MHz → 1 MHz divider chain.

## Interface
Parameters:
- `CH`, 4: number of sensor channels (1..8).
- `CLK_HZ`, 100_000_000: frequency of `clk`; must be a multiple of 1 MHz.
- `DIST_W`, 9: distance width in cm per channel.
- `TRIG_US`, 10: trigger pulse length in µs.
- `TIMEOUT_US`, 25_000: maximum wait for the echo rise plus echo high time per channel.
- `GUARD_US`, 10_000: idle gap after each channel before the next trigger (crosstalk guard).

Ports:
- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-high reset.
- `enable` in 1: when high, scanning runs continuously.
- `echo` in CH: raw sensor echo lines, asynchronous.
- `trig` out CH: trigger outputs; at most one bit high at any time.
- `distance` out CH*DIST_W: channel i occupies bits [i*DIST_W +: DIST_W].
- `timeout` out CH: sticky per channel until that channel's next completed measurement.
- `valid` out 1: one-cycle pulse when any channel's distance/timeout is updated.
- `valid_ch` out $clog2(CH) (min 1): index of the updated channel, qualified by `valid`.

## Operation
- Each `echo` bit passes through a 2-flop synchroniser. Edges are detected on the synchronised value.
- `sonic_tick` generates `us_tick`, a one-cycle strobe every CLK_HZ/1e6 cycles, free-running from reset. All µs timing counts `us_tick`.
- FSM states: IDLE, TRIG, WAIT_RISE, MEASURE, GUARD. A channel pointer `ch` advances only at the end of each GUARD.
  - IDLE: if `enable`, go to TRIG on the next `us_tick` and clear the µs counter.
  - TRIG: `trig[ch]`=1 for exactly TRIG_US ticks, then go to WAIT_RISE.
  - WAIT_RISE: on a synced rising edge of `echo[ch]`, go to MEASURE and clear the cm counters. If TIMEOUT_US ticks elapse first, go to the timeout exit.
  - MEASURE: a sub-counter counts ticks 0..57. On wrap, the cm counter increments, saturating at 2^DIST_W−1.
    - Synced falling edge: write the cm count to `distance[ch]`, clear `timeout[ch]`, pulse `valid`, go to GUARD.
    - TIMEOUT_US total ticks since TRIG exit: take the timeout exit.
  - Timeout exit: set `distance[ch]` to all ones, set `timeout[ch]`, pulse `valid`, go to GUARD.
  - GUARD: wait GUARD_US ticks, then `ch` = (ch+1) mod CH. Go to TRIG if `enable`, else IDLE.
- Deasserting `enable` never aborts a measurement. The current channel completes through GUARD, then the FSM parks in IDLE with the pointer advanced.
- An echo already high on entry to WAIT_RISE is ignored until it falls and rises again. An echo on a non-selected channel is ignored.

## Timing
- Reset values: `trig`=0, `distance`=0, `timeout`=0, `valid`=0, `valid_ch`=0, `ch`=0, FSM=IDLE, prescaler=0.
- `rst` asserted mid-operation: all of the above apply on the next edge, and `trig` drops within one cycle.
- Echo latency: a raw `echo` fall produces the `valid` pulse 3 cycles later (2 sync + 1 edge/register).
- Resolution: 58 µs per cm, truncated. An echo high for 580–637 µs reads 10.
- A falling edge and the timeout in the same cycle: the falling edge wins, and the measured value is stored.
- `trig` rise aligns to a `us_tick` cycle. Its width is exactly TRIG_US*CLK_HZ/1e6 cycles.

## Configuration
- `SONIC_AVG_EN` defined: each stored distance is (old + new) >> 1, computed at DIST_W+1 bits. A direct load occurs on the first sample after reset, or when the previous sample was a timeout. Timeouts are never averaged.
- `SONIC_AVG_EN` undefined: the raw sample is stored.

## Structure
- `sonic_pkg` holds:
  - the FSM state enum;
  - `US_PER_CM` = 58;
  - the helper function computing the prescaler count from CLK_HZ.
- Sub-module `sonic_tick`: parametrised µs strobe generator (CLK_HZ). Everything else lives in `sonic_scanner`.

## Test plan
All scenarios use CLK_HZ=1_000_000, TRIG_US=10, TIMEOUT_US=25_000 and GUARD_US=100; CH=4 and DIST_W=9 unless stated.
- Echo: channel 0 echo rises 100 µs after trig falls and stays high 580 µs → `distance[0]`=10, `timeout[0]`=0, one `valid` with `valid_ch`=0, then `trig[1]` fires after the guard.
- No echo on channel 2 → after 25_000 µs, `distance[2]`=511, `timeout[2]`=1. The next successful measurement of channel 2 clears the flag.
- Saturation: DIST_W=6, echo high 58*70 µs → `distance`=63, no timeout.
- Enable drop: deassert `enable` during channel 1 MEASURE → channel 1 result is stored, the FSM idles, no further `trig`. Reassert → next `trig` is on channel 2.
- Reset: assert `rst` during TRIG → `trig`=0 next cycle, all outputs cleared, scanning restarts at channel 0.
- Averaging: with `SONIC_AVG_EN`, samples 10 then 20 on channel 0 → stored values 10 then 15.
